cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Writeback arbiter sharing the single result-broadcast bus (CDB) feeding the RoB, RS and LSB between the ALU and LSU. Each source owns a small FIFO that absorbs same-cycle completions. One entry per cycle is granted round-robin and driven as a registered one-cycle pulse. The whole block is flushed by the RoB's rollback.

## Interface
Parameters:
- DEPTH, 4, entries per source FIFO (power of two, ≥2)
- CNT_W, 3, count width; 2^CNT_W > DEPTH

Ports:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous reset, active-low
- rdy_in  in  1  global enable; low = freeze
- rollback_in  in  1  RoB misprediction flush
- alu_valid_in  in  1  ALU result present
- alu_rob_id_in  in  5  ALU RoB tag (1..16; 0 = none)
- alu_result_in  in  32  ALU data
- alu_target_pc_in  in  32  branch target
- alu_jump_in  in  1  branch taken
- alu_ready_out  out  1  ALU FIFO can accept
- lsu_valid_in  in  1  LSU result present
- lsu_rob_id_in  in  5  LSU RoB tag
- lsu_result_in  in  32  load data
- lsu_ready_out  out  1  LSU FIFO can accept
- cdb_valid_out  out  1  broadcast valid, one-cycle pulse
- cdb_src_out  out  1  0 = ALU, 1 = LSU
- cdb_rob_id_out  out  5  broadcast tag
- cdb_result_out  out  32  broadcast data
- cdb_target_pc_out  out  32  ALU target; 0 for LSU
- cdb_jump_out  out  1  ALU taken; 0 for LSU
- alu_count_out  out  CNT_W  ALU FIFO occupancy
- lsu_count_out  out  CNT_W  LSU FIFO occupancy

## Operation
- Each source has a circular FIFO with head/tail pointers and count; pointers wrap at DEPTH.
- xxx_ready_out = rdy_in && count < DEPTH. This is combinational on current count only. A pop in the same cycle does not free a slot.
- Accept = valid && ready. Tag 0 is accepted and discarded (never enqueued, never broadcast).
- Grant, per cycle with rdy_in high:
  - exactly one FIFO non-empty → that FIFO;
  - both non-empty → the source not granted last (last_grant register).
- The granted head is popped and registered onto the cdb_* outputs with cdb_valid_out=1, and last_grant is updated.
- No grant → cdb_valid_out=0; data outputs hold their last values.
- Counts: count ← count + push − pop. Push and pop in the same cycle leave the count unchanged.
- rollback_in high at an edge, regardless of rdy_in:
  - both FIFOs emptied, all pointers and counts cleared;
  - cdb_valid_out ← 0, last_grant ← LSU (ALU wins the next tie);
  - inputs presented that cycle are dropped.
- rdy_in low, no rollback: no push, no pop, last_grant held, cdb_valid_out ← 0.
- Reset: all pointers and counts 0, last_grant = LSU. cdb_valid_out, cdb_src_out, cdb_rob_id_out, cdb_result_out, cdb_target_pc_out, cdb_jump_out and both count outputs are 0. Ready outputs follow the ready rule (count 0).

## Timing
- Without the macro: input accepted at edge N, earliest broadcast registered at edge N+1 (valid during cycle N+1..N+2).
- Same-cycle ALU+LSU completions with empty FIFOs: the winner broadcasts after edge N+1, the loser after edge N+2.
- Throughput: one broadcast per cycle; a full FIFO drains at most one entry per cycle.
- Asserting rst_in low mid-operation clears state immediately (asynchronous), not at the next edge.
- Release of rst_in is synchronised externally; the first active edge after release may accept inputs.

## Configuration
- CDB_BYPASS_EN defined: a source whose FIFO is empty and which wins arbitration at edge N drives its input straight into the cdb_* registers at edge N, without enqueuing.
  - Arbitration at edge N counts that source as a candidate alongside the non-empty FIFOs.
  - A losing simultaneous input is enqueued normally.
  - Latency: input accepted at edge N, broadcast during cycle N..N+1.
- CDB_BYPASS_EN not defined: all inputs pass through the FIFOs, with the latency given under Timing.

## Test plan
- Single ALU result, tag 3, data 0x11, target 0x100, jump 1, idle bus → one cdb pulse with src 0 and those exact values after 1 edge (0 edges with CDB_BYPASS_EN); alu_count_out returns to 0.
- ALU tag 2 and LSU tag 5 in the same cycle after reset → ALU broadcast first, then LSU on the next cycle; repeated ties alternate LSU, ALU.
- Push 4 ALU results back-to-back while LSU keeps the bus granted → alu_ready_out low once count = 4; a 5th valid is not accepted; ALU entries later drain in order.
- Fill both FIFOs to 3, assert rollback_in with both inputs valid → next cycle counts 0, cdb_valid_out 0, nothing from the old entries is ever broadcast.
- rdy_in low for 3 cycles with both FIFOs holding 2 → counts unchanged, no cdb pulses, ready outputs 0; normal draining resumes when rdy_in returns high.
- Tag 0 on ALU input → no enqueue and no broadcast. rst_in pulsed low between edges → all outputs 0 immediately.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin writeback arbiter for the common data bus.
// The ALU and the LSU each own a small circular FIFO. One head entry is
// granted per cycle and broadcast as a registered one-cycle pulse.
// Optional feature macro: CDB_BYPASS_EN. When it is defined, a source with an
// empty FIFO that wins arbitration goes straight to the bus without enqueuing.
module cdb_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rollback_in,
  input  logic             alu_valid_in,
  input  logic [4:0]       alu_rob_id_in,
  input  logic [31:0]      alu_result_in,
  input  logic [31:0]      alu_target_pc_in,
  input  logic             alu_jump_in,
  output logic             alu_ready_out,
  input  logic             lsu_valid_in,
  input  logic [4:0]       lsu_rob_id_in,
  input  logic [31:0]      lsu_result_in,
  output logic             lsu_ready_out,
  output logic             cdb_valid_out,
  output logic             cdb_src_out,
  output logic [4:0]       cdb_rob_id_out,
  output logic [31:0]      cdb_result_out,
  output logic [31:0]      cdb_target_pc_out,
  output logic             cdb_jump_out,
  output logic [CNT_W-1:0] alu_count_out,
  output logic [CNT_W-1:0] lsu_count_out
);
  localparam int   PTR_W   = $clog2(DEPTH);
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  // FIFO storage (data only, never reset)
  logic [4:0]       r_alu_tag [DEPTH];
  logic [31:0]      r_alu_res [DEPTH];
  logic [31:0]      r_alu_pc  [DEPTH];
  logic             r_alu_jmp [DEPTH];
  logic [4:0]       r_lsu_tag [DEPTH];
  logic [31:0]      r_lsu_res [DEPTH];

  logic [PTR_W-1:0] r_alu_head, r_alu_tail, r_lsu_head, r_lsu_tail;
  logic [CNT_W-1:0] r_alu_cnt, r_lsu_cnt;
  logic             r_last_gnt;
  logic             r_cdb_valid, r_cdb_src, r_cdb_jmp;
  logic [4:0]       r_cdb_tag;
  logic [31:0]      r_cdb_res, r_cdb_pc;

  logic w_alu_ne, w_lsu_ne, w_alu_rdy, w_lsu_rdy, w_alu_acc, w_lsu_acc;
  logic w_alu_cand, w_lsu_cand, w_gnt_any, w_gnt_lsu;
  logic w_alu_take, w_lsu_take, w_alu_pop, w_lsu_pop, w_alu_push, w_lsu_push;
  logic [4:0]  w_sel_tag;
  logic [31:0] w_sel_res, w_sel_pc;
  logic        w_sel_jmp;

  assign w_alu_ne  = (r_alu_cnt != '0);
  assign w_lsu_ne  = (r_lsu_cnt != '0);
  // Ready looks at the current count only; a same-cycle pop does not free a slot.
  assign w_alu_rdy = rdy_in && (r_alu_cnt < CNT_W'(DEPTH));
  assign w_lsu_rdy = rdy_in && (r_lsu_cnt < CNT_W'(DEPTH));
  // Tag 0 completes the handshake but is dropped.
  assign w_alu_acc = alu_valid_in && w_alu_rdy && !rollback_in && (alu_rob_id_in != 5'd0);
  assign w_lsu_acc = lsu_valid_in && w_lsu_rdy && !rollback_in && (lsu_rob_id_in != 5'd0);

`ifdef CDB_BYPASS_EN
  assign w_alu_cand = w_alu_ne || w_alu_acc;
  assign w_lsu_cand = w_lsu_ne || w_lsu_acc;
`else
  assign w_alu_cand = w_alu_ne;
  assign w_lsu_cand = w_lsu_ne;
`endif

  // On a tie the source that was not granted last wins.
  assign w_gnt_any  = rdy_in && !rollback_in && (w_alu_cand || w_lsu_cand);
  assign w_gnt_lsu  = w_lsu_cand && (!w_alu_cand || (r_last_gnt == SRC_ALU));
  assign w_alu_take = w_gnt_any && !w_gnt_lsu;
  assign w_lsu_take = w_gnt_any && w_gnt_lsu;
  assign w_alu_pop  = w_alu_take && w_alu_ne;
  assign w_lsu_pop  = w_lsu_take && w_lsu_ne;
  // A winner with an empty FIFO (bypass build only) is not enqueued.
  assign w_alu_push = w_alu_acc && !(w_alu_take && !w_alu_ne);
  assign w_lsu_push = w_lsu_acc && !(w_lsu_take && !w_lsu_ne);

  // Select the broadcast payload: FIFO head, or the live input when bypassing.
  always_comb begin
    w_sel_tag = '0;
    w_sel_res = '0;
    w_sel_pc  = '0;
    w_sel_jmp = 1'b0;
    if (w_gnt_lsu) begin
      w_sel_tag = w_lsu_ne ? r_lsu_tag[r_lsu_head] : lsu_rob_id_in;
      w_sel_res = w_lsu_ne ? r_lsu_res[r_lsu_head] : lsu_result_in;
    end else begin
      w_sel_tag = w_alu_ne ? r_alu_tag[r_alu_head] : alu_rob_id_in;
      w_sel_res = w_alu_ne ? r_alu_res[r_alu_head] : alu_result_in;
      w_sel_pc  = w_alu_ne ? r_alu_pc[r_alu_head]  : alu_target_pc_in;
      w_sel_jmp = w_alu_ne ? r_alu_jmp[r_alu_head] : alu_jump_in;
    end
  end

  // Write accepted entries into the FIFO storage at the tail.
  always_ff @(posedge clk_in) begin
    if (w_alu_push) begin
      r_alu_tag[r_alu_tail] <= alu_rob_id_in;
      r_alu_res[r_alu_tail] <= alu_result_in;
      r_alu_pc[r_alu_tail]  <= alu_target_pc_in;
      r_alu_jmp[r_alu_tail] <= alu_jump_in;
    end
    if (w_lsu_push) begin
      r_lsu_tag[r_lsu_tail] <= lsu_rob_id_in;
      r_lsu_res[r_lsu_tail] <= lsu_result_in;
    end
  end

  // Pointers, counts, arbitration history and the registered bus outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_alu_head  <= '0;
      r_alu_tail  <= '0;
      r_lsu_head  <= '0;
      r_lsu_tail  <= '0;
      r_alu_cnt   <= '0;
      r_lsu_cnt   <= '0;
      r_last_gnt  <= SRC_LSU;
      r_cdb_valid <= 1'b0;
      r_cdb_src   <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_res   <= '0;
      r_cdb_pc    <= '0;
      r_cdb_jmp   <= 1'b0;
    end else if (rollback_in) begin
      r_alu_head  <= '0;
      r_alu_tail  <= '0;
      r_lsu_head  <= '0;
      r_lsu_tail  <= '0;
      r_alu_cnt   <= '0;
      r_lsu_cnt   <= '0;
      r_last_gnt  <= SRC_LSU;
      r_cdb_valid <= 1'b0;
    end else begin
      if (w_alu_push) r_alu_tail <= r_alu_tail + PTR_W'(1);
      if (w_alu_pop)  r_alu_head <= r_alu_head + PTR_W'(1);
      if (w_lsu_push) r_lsu_tail <= r_lsu_tail + PTR_W'(1);
      if (w_lsu_pop)  r_lsu_head <= r_lsu_head + PTR_W'(1);
      r_alu_cnt   <= r_alu_cnt + CNT_W'(w_alu_push) - CNT_W'(w_alu_pop);
      r_lsu_cnt   <= r_lsu_cnt + CNT_W'(w_lsu_push) - CNT_W'(w_lsu_pop);
      r_cdb_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_last_gnt <= w_gnt_lsu;
        r_cdb_src  <= w_gnt_lsu;
        r_cdb_tag  <= w_sel_tag;
        r_cdb_res  <= w_sel_res;
        r_cdb_pc   <= w_sel_pc;
        r_cdb_jmp  <= w_sel_jmp;
      end
    end
  end

  assign alu_ready_out     = w_alu_rdy;
  assign lsu_ready_out     = w_lsu_rdy;
  assign cdb_valid_out     = r_cdb_valid;
  assign cdb_src_out       = r_cdb_src;
  assign cdb_rob_id_out    = r_cdb_tag;
  assign cdb_result_out    = r_cdb_res;
  assign cdb_target_pc_out = r_cdb_pc;
  assign cdb_jump_out      = r_cdb_jmp;
  assign alu_count_out     = r_alu_cnt;
  assign lsu_count_out     = r_lsu_cnt;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (default build, FIFO path latency).
module tb_cdb_arbiter;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, rollback_in;
  logic             alu_valid_in, alu_jump_in, lsu_valid_in;
  logic [4:0]       alu_rob_id_in, lsu_rob_id_in;
  logic [31:0]      alu_result_in, alu_target_pc_in, lsu_result_in;
  logic             alu_ready_out, lsu_ready_out;
  logic             cdb_valid_out, cdb_src_out, cdb_jump_out;
  logic [4:0]       cdb_rob_id_out;
  logic [31:0]      cdb_result_out, cdb_target_pc_out;
  logic [CNT_W-1:0] alu_count_out, lsu_count_out;

  int n_err = 0;
  int n_chk = 0;

  cdb_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rollback_in(rollback_in),
    .alu_valid_in(alu_valid_in), .alu_rob_id_in(alu_rob_id_in),
    .alu_result_in(alu_result_in), .alu_target_pc_in(alu_target_pc_in),
    .alu_jump_in(alu_jump_in), .alu_ready_out(alu_ready_out),
    .lsu_valid_in(lsu_valid_in), .lsu_rob_id_in(lsu_rob_id_in),
    .lsu_result_in(lsu_result_in), .lsu_ready_out(lsu_ready_out),
    .cdb_valid_out(cdb_valid_out), .cdb_src_out(cdb_src_out),
    .cdb_rob_id_out(cdb_rob_id_out), .cdb_result_out(cdb_result_out),
    .cdb_target_pc_out(cdb_target_pc_out), .cdb_jump_out(cdb_jump_out),
    .alu_count_out(alu_count_out), .lsu_count_out(lsu_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_res(input logic [4:0] t);
    return 32'hA000_0000 | {27'd0, t};
  endfunction
  function automatic logic [31:0] alu_pc(input logic [4:0] t);
    return 32'h0000_1000 + {23'd0, t, 4'd0};
  endfunction
  function automatic logic alu_jmp(input logic [4:0] t);
    return t[0];
  endfunction
  function automatic logic [31:0] lsu_res(input logic [4:0] t);
    return 32'hB000_0000 | {27'd0, t};
  endfunction

  // Drive one cycle of inputs, clock it, then check the bus and both counts.
  task automatic cyc(input string nm,
                     input logic av, input logic [4:0] at,
                     input logic lv, input logic [4:0] lt,
                     input logic ev, input logic es, input logic [4:0] et,
                     input int eac, input int elc);
    alu_valid_in     = av;
    alu_rob_id_in    = at;
    alu_result_in    = alu_res(at);
    alu_target_pc_in = alu_pc(at);
    alu_jump_in      = alu_jmp(at);
    lsu_valid_in     = lv;
    lsu_rob_id_in    = lt;
    lsu_result_in    = lsu_res(lt);
    @(posedge clk_in); #1;
    chk({nm, ".vld"}, cdb_valid_out, ev);
    if (ev) begin
      chk({nm, ".src"}, cdb_src_out, es);
      chk({nm, ".tag"}, cdb_rob_id_out, et);
      chk({nm, ".res"}, cdb_result_out, es ? lsu_res(et) : alu_res(et));
      chk({nm, ".pc"},  cdb_target_pc_out, es ? 32'd0 : alu_pc(et));
      chk({nm, ".jmp"}, cdb_jump_out, es ? 1'b0 : alu_jmp(et));
    end
    chk({nm, ".acnt"}, alu_count_out, 64'(eac));
    chk({nm, ".lcnt"}, lsu_count_out, 64'(elc));
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; rollback_in = 1'b0;
    alu_valid_in = 1'b0; alu_rob_id_in = '0; alu_result_in = '0;
    alu_target_pc_in = '0; alu_jump_in = 1'b0;
    lsu_valid_in = 1'b0; lsu_rob_id_in = '0; lsu_result_in = '0;
    #2 rst_in = 1'b0;
    #10;
    chk("rst.vld", cdb_valid_out, 0);
    chk("rst.src", cdb_src_out, 0);
    chk("rst.tag", cdb_rob_id_out, 0);
    chk("rst.res", cdb_result_out, 0);
    chk("rst.pc", cdb_target_pc_out, 0);
    chk("rst.jmp", cdb_jump_out, 0);
    chk("rst.acnt", alu_count_out, 0);
    chk("rst.lcnt", lsu_count_out, 0);
    chk("rst.ardy", alu_ready_out, 1);
    chk("rst.lrdy", lsu_ready_out, 1);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Single ALU result through the FIFO
    alu_valid_in = 1'b1; alu_rob_id_in = 5'd3; alu_result_in = 32'h11;
    alu_target_pc_in = 32'h100; alu_jump_in = 1'b1;
    @(posedge clk_in); #1;
    chk("one.e0.vld", cdb_valid_out, 0);
    chk("one.e0.acnt", alu_count_out, 1);
    alu_valid_in = 1'b0;
    @(posedge clk_in); #1;
    chk("one.e1.vld", cdb_valid_out, 1);
    chk("one.e1.src", cdb_src_out, 0);
    chk("one.e1.tag", cdb_rob_id_out, 3);
    chk("one.e1.res", cdb_result_out, 32'h11);
    chk("one.e1.pc", cdb_target_pc_out, 32'h100);
    chk("one.e1.jmp", cdb_jump_out, 1);
    chk("one.e1.acnt", alu_count_out, 0);
    @(posedge clk_in); #1;
    chk("one.e2.vld", cdb_valid_out, 0);
    chk("one.e2.hold", cdb_result_out, 32'h11);

    // Asynchronous reset pulse between edges with one entry queued
    cyc("prerst", 1, 4, 0, 0, 0, 0, 0, 1, 0);
    alu_valid_in = 1'b0;
    #2 rst_in = 1'b0;
    #1;
    chk("arst.vld", cdb_valid_out, 0);
    chk("arst.tag", cdb_rob_id_out, 0);
    chk("arst.res", cdb_result_out, 0);
    chk("arst.pc", cdb_target_pc_out, 0);
    chk("arst.jmp", cdb_jump_out, 0);
    chk("arst.acnt", alu_count_out, 0);
    #1 rst_in = 1'b1;
    cyc("postrst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Same-cycle completions after reset: ALU first, then LSU
    cyc("tie0", 1, 2, 1, 5, 0, 0, 0, 1, 1);
    cyc("tie1", 0, 0, 0, 0, 1, 0, 2, 0, 1);
    cyc("tie2", 0, 0, 0, 0, 1, 1, 5, 0, 0);
    // Back-to-back ties keep alternating
    cyc("alt1", 1, 9, 1, 11, 0, 0, 0, 1, 1);
    cyc("alt2", 1, 10, 1, 12, 1, 0, 9, 1, 2);
    cyc("alt3", 0, 0, 0, 0, 1, 1, 11, 1, 1);
    cyc("alt4", 0, 0, 0, 0, 1, 0, 10, 0, 1);
    cyc("alt5", 0, 0, 0, 0, 1, 1, 12, 0, 0);

    // Fill the ALU FIFO while the LSU shares the bus
    cyc("full1", 1, 1, 1, 11, 0, 0, 0, 1, 1);
    cyc("full2", 1, 2, 1, 12, 1, 0, 1, 1, 2);
    cyc("full3", 1, 3, 1, 13, 1, 1, 11, 2, 2);
    cyc("full4", 1, 4, 1, 14, 1, 0, 2, 2, 3);
    cyc("full5", 1, 5, 0, 0, 1, 1, 12, 3, 2);
    cyc("full6", 1, 6, 0, 0, 1, 0, 3, 3, 2);
    cyc("full7", 1, 7, 0, 0, 1, 1, 13, 4, 1);
    chk("full7.ardy", alu_ready_out, 0);
    chk("full7.lrdy", lsu_ready_out, 1);
    cyc("full8", 1, 8, 0, 0, 1, 0, 4, 3, 1);
    cyc("full9", 0, 0, 0, 0, 1, 1, 14, 3, 0);
    cyc("full10", 0, 0, 0, 0, 1, 0, 5, 2, 0);
    cyc("full11", 0, 0, 0, 0, 1, 0, 6, 1, 0);
    cyc("full12", 0, 0, 0, 0, 1, 0, 7, 0, 0);
    cyc("full13", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Rollback with both FIFOs at 3 and both inputs valid
    cyc("rb1", 1, 1, 1, 6, 0, 0, 0, 1, 1);
    cyc("rb2", 1, 2, 1, 7, 1, 1, 6, 2, 1);
    cyc("rb3", 1, 3, 1, 8, 1, 0, 1, 2, 2);
    cyc("rb4", 1, 4, 1, 9, 1, 1, 7, 3, 2);
    cyc("rb5", 1, 5, 1, 10, 1, 0, 2, 3, 3);
    rollback_in = 1'b1;
    cyc("rb6", 1, 15, 1, 16, 0, 0, 0, 0, 0);
    rollback_in = 1'b0;
    for (int i = 0; i < 4; i++) cyc("rbidle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Freeze with rdy_in low, both FIFOs holding 2
    cyc("rdy1", 1, 1, 1, 6, 0, 0, 0, 1, 1);
    cyc("rdy2", 1, 2, 1, 7, 1, 0, 1, 1, 2);
    cyc("rdy3", 1, 3, 1, 8, 1, 1, 6, 2, 2);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc("frz", 1, 9, 1, 10, 0, 0, 0, 2, 2);
      chk("frz.ardy", alu_ready_out, 0);
      chk("frz.lrdy", lsu_ready_out, 0);
    end
    rdy_in = 1'b1;
    cyc("thaw1", 0, 0, 0, 0, 1, 0, 2, 1, 2);
    cyc("thaw2", 0, 0, 0, 0, 1, 1, 7, 1, 1);
    cyc("thaw3", 0, 0, 0, 0, 1, 0, 3, 0, 1);
    cyc("thaw4", 0, 0, 0, 0, 1, 1, 8, 0, 0);
    cyc("thaw5", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Tag 0 is accepted but never queued or broadcast
    cyc("tag0a", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("tag0b", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
